panel_dma_ctrl: RTL and testbench

Front-panel memory access controller for the Altair core. It is the parametrised successor to the jam-instruction examine/deposit scheme. It takes single-cycle panel command strobes (examine, examine next, deposit, deposit next), gains bus ownership from the CPU through a hold/hold-ack handshake, and performs direct reads and writes on the synchronous memory bus. It sits between the debounced panel switches and the memory-map decode, and drives the address/data LEDs.

---
 rtl/panel_dma_ctrl.sv | 145 ++++++++++++++
 tb/tb_panel_dma_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_dma_ctrl.sv
// Front-panel examine/deposit controller: borrows the memory bus from the CPU via
// hold/hold-ack, performs one write and/or read, and updates the panel address/data LEDs.
module panel_dma_ctrl #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int RD_LATENCY   = 1,
    parameter int HOLD_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pause,
    input  logic                  examine_stb,
    input  logic                  examine_next_stb,
    input  logic                  deposit_stb,
    input  logic                  deposit_next_stb,
    input  logic [ADDR_WIDTH-1:0] sw_addr,
    input  logic [DATA_WIDTH-1:0] sw_data,
    output logic                  hold_req,
    input  logic                  hold_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] panel_addr,
    output logic [DATA_WIDTH-1:0] panel_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cmd_drop
);

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_WRITE, S_READ, S_WAIT, S_RELEASE
    } state_t;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] cur_addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [DATA_WIDTH-1:0] panel_data_reg;
    logic                  is_write_reg;
    logic [15:0]           hold_cnt_reg;
    logic [2:0]            wait_cnt_reg;
    logic                  hold_req_reg;
    logic                  done_reg;
    logic                  err_reg;
    logic                  cmd_drop_reg;

    logic       any_stb;
    logic [2:0] stb_count;

    assign any_stb   = examine_stb | examine_next_stb | deposit_stb | deposit_next_stb;
    assign stb_count = 3'(examine_stb) + 3'(examine_next_stb)
                     + 3'(deposit_stb) + 3'(deposit_next_stb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cur_addr_reg   <= '0;
            wdata_reg      <= '0;
            panel_data_reg <= '0;
            is_write_reg   <= 1'b0;
            hold_cnt_reg   <= '0;
            wait_cnt_reg   <= '0;
            hold_req_reg   <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            cmd_drop_reg   <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            // Any strobe that does not start a command is reported, including losers of a tie
            cmd_drop_reg <= any_stb && (state_reg != S_IDLE || !pause || stb_count > 3'd1);

            case (state_reg)
                S_IDLE: begin
                    if (any_stb && pause) begin
                        if (examine_stb) begin
                            cur_addr_reg <= sw_addr;
                            is_write_reg <= 1'b0;
                        end else if (examine_next_stb) begin
                            cur_addr_reg <= cur_addr_reg + 1'b1;
                            is_write_reg <= 1'b0;
                        end else if (deposit_stb) begin
                            is_write_reg <= 1'b1;
                        end else begin
                            cur_addr_reg <= cur_addr_reg + 1'b1;
                            is_write_reg <= 1'b1;
                        end
                        wdata_reg    <= sw_data;
                        hold_cnt_reg <= '0;
                        hold_req_reg <= 1'b1;
                        state_reg    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hold_ack) begin
                        state_reg <= is_write_reg ? S_WRITE : S_READ;
                    end else if (hold_cnt_reg == 16'(HOLD_TIMEOUT - 1)) begin
                        err_reg      <= 1'b1;
                        hold_req_reg <= 1'b0;
                        state_reg    <= S_IDLE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 16'd1;
                    end
                end
                S_WRITE, S_READ, S_WAIT: begin
                    if (!hold_ack) begin
                        err_reg      <= 1'b1;
                        hold_req_reg <= 1'b0;
                        state_reg    <= S_IDLE;
                    end else if (state_reg == S_WRITE) begin
                        state_reg <= S_READ;
                    end else if (state_reg == S_READ) begin
                        wait_cnt_reg <= 3'(RD_LATENCY);
                        state_reg    <= S_WAIT;
                    end else if (wait_cnt_reg == 3'd1) begin
                        panel_data_reg <= mem_rdata;
                        hold_req_reg   <= 1'b0;
                        done_reg       <= 1'b1;
                        state_reg      <= S_RELEASE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 3'd1;
                    end
                end
                S_RELEASE: state_reg <= S_IDLE;
                default:   state_reg <= S_IDLE;
            endcase
        end
    end

    // Strobes are gated by hold_ack so the abort cycle never touches memory
    assign mem_rd     = (state_reg == S_READ)  && hold_ack;
    assign mem_we     = (state_reg == S_WRITE) && hold_ack;
    assign mem_wdata  = mem_we ? wdata_reg : '0;
    assign mem_addr   = hold_req_reg ? cur_addr_reg : '0;
    assign hold_req   = hold_req_reg;
    assign panel_addr = cur_addr_reg;
    assign panel_data = panel_data_reg;
    assign busy       = (state_reg != S_IDLE);
    assign done       = done_reg;
    assign err        = err_reg;
    assign cmd_drop   = cmd_drop_reg;

endmodule

// File: tb/tb_panel_dma_ctrl.sv
// Directed bench for panel_dma_ctrl: main DUT (RD_LATENCY=1, HOLD_TIMEOUT=10) with a
// memory model, plus a RD_LATENCY=3 instance for latency and async-reset checks.
module tb_panel_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, rst_n_b;
    logic        pause;
    logic        examine_stb, examine_next_stb, deposit_stb, deposit_next_stb;
    logic [15:0] sw_addr;
    logic [7:0]  sw_data;
    logic        hold_ack;

    logic        hold_req, mem_rd, mem_we, busy, done, err, cmd_drop;
    logic [15:0] mem_addr, panel_addr;
    logic [7:0]  mem_wdata, mem_rdata, panel_data;

    logic        b_hold_req, b_mem_rd, b_mem_we, b_busy, b_done, b_err, b_cmd_drop;
    logic [15:0] b_mem_addr, b_panel_addr;
    logic [7:0]  b_mem_wdata, b_mem_rdata, b_panel_data;

    logic [7:0]  mem [0:65535];
    logic        tb_we;
    logic [15:0] tb_waddr;
    logic [7:0]  tb_wdata;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    always #5 clk = ~clk;

    panel_dma_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .RD_LATENCY(1), .HOLD_TIMEOUT(10)) dut (
        .clk(clk), .rst_n(rst_n), .pause(pause),
        .examine_stb(examine_stb), .examine_next_stb(examine_next_stb),
        .deposit_stb(deposit_stb), .deposit_next_stb(deposit_next_stb),
        .sw_addr(sw_addr), .sw_data(sw_data),
        .hold_req(hold_req), .hold_ack(hold_ack),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .panel_addr(panel_addr), .panel_data(panel_data),
        .busy(busy), .done(done), .err(err), .cmd_drop(cmd_drop)
    );

    panel_dma_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .RD_LATENCY(3), .HOLD_TIMEOUT(10)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .pause(pause),
        .examine_stb(examine_stb), .examine_next_stb(examine_next_stb),
        .deposit_stb(deposit_stb), .deposit_next_stb(deposit_next_stb),
        .sw_addr(sw_addr), .sw_data(sw_data),
        .hold_req(b_hold_req), .hold_ack(hold_ack),
        .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .mem_we(b_mem_we),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .panel_addr(b_panel_addr), .panel_data(b_panel_data),
        .busy(b_busy), .done(b_done), .err(b_err), .cmd_drop(b_cmd_drop)
    );

    // Synchronous memory: one-cycle read latency, with a bench-side preload port
    always @(posedge clk) begin
        if (tb_we)       mem[tb_waddr] <= tb_wdata;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_rd)      mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (b_mem_rd) b_mem_rdata <= b_mem_addr[7:0] ^ 8'h5A;
    end

    always @(negedge clk) begin
        if (mem_rd && mem_we)                 viol++;
        if ((mem_rd || mem_we) && !hold_req)  viol++;
        if (b_mem_rd && b_mem_we)             viol++;
        if ((b_mem_rd || b_mem_we) && !b_hold_req) viol++;
    end

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    // Issues strobes {examine, examine_next, deposit, deposit_next} and records event cycles
    task automatic do_cmd(input logic [3:0] stb, input logic [15:0] addr, input logic [7:0] data,
                          output int rd_cyc, output int we_cyc, output int done_cyc,
                          output int err_cyc, output int drop_cyc, output int hold_cyc,
                          output logic [15:0] rd_addr, output logic [15:0] we_addr,
                          output logic [7:0] we_data);
        rd_cyc = -1; we_cyc = -1; done_cyc = -1; err_cyc = -1; drop_cyc = -1; hold_cyc = 0;
        rd_addr = '0; we_addr = '0; we_data = '0;
        sw_addr = addr; sw_data = data;
        {examine_stb, examine_next_stb, deposit_stb, deposit_next_stb} = stb;
        @(posedge clk); #1;
        {examine_stb, examine_next_stb, deposit_stb, deposit_next_stb} = 4'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (mem_rd && rd_cyc < 0) begin rd_cyc = c; rd_addr = mem_addr; end
            if (mem_we && we_cyc < 0) begin we_cyc = c; we_addr = mem_addr; we_data = mem_wdata; end
            if (cmd_drop && drop_cyc < 0) drop_cyc = c;
            if (hold_req) hold_cyc++;
            if (done) done_cyc = c;
            if (err)  err_cyc = c;
            if (done || err) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_n_b = 1'b0; pause = 1'b1; hold_ack = 1'b1; tb_we = 1'b0;
        {examine_stb, examine_next_stb, deposit_stb, deposit_next_stb} = 4'b0;
        sw_addr = 16'h0; sw_data = 8'h0; tb_waddr = '0; tb_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({hold_req, mem_rd, mem_we, busy, done, err, cmd_drop, mem_addr, panel_addr, panel_data}
            !== '0) begin
            errors++;
            $display("FAIL reset_outputs got hreq=%b busy=%b addr=%h pa=%h pd=%h want all 0",
                     hold_req, busy, mem_addr, panel_addr, panel_data);
        end
        rst_n = 1'b1; rst_n_b = 1'b1;
        @(posedge clk); #1;
        $display("reset: outputs checked, reset released");
    endtask

    task automatic test_examine();
        int rc, wc, dc, ec, drc, hc; logic [15:0] ra, wa; logic [7:0] wd;
        do_cmd(4'b1000, 16'h1234, 8'h00, rc, wc, dc, ec, drc, hc, ra, wa, wd);
        checks++; if (rc !== 2) begin errors++; $display("FAIL examine_rd_cycle got %0d want 2", rc); end
        checks++; if (ra !== 16'h1234) begin errors++; $display("FAIL examine_rd_addr got %h want 1234", ra); end
        checks++; if (dc !== 4) begin errors++; $display("FAIL examine_done_cycle got %0d want 4", dc); end
        checks++; if (hc !== 3) begin errors++; $display("FAIL examine_hold_cycles got %0d want 3", hc); end
        checks++; if (wc !== -1) begin errors++; $display("FAIL examine_no_write got %0d want -1", wc); end
        checks++; if (panel_data !== 8'hA5) begin errors++; $display("FAIL examine_panel_data got %h want a5", panel_data); end
        checks++; if (panel_addr !== 16'h1234) begin errors++; $display("FAIL examine_panel_addr got %h want 1234", panel_addr); end
        $display("examine 1234: rd@%0d done@%0d data=%h", rc, dc, panel_data);
    endtask

    task automatic test_deposit();
        int rc, wc, dc, ec, drc, hc; logic [15:0] ra, wa; logic [7:0] wd;
        do_cmd(4'b1000, 16'h0100, 8'h00, rc, wc, dc, ec, drc, hc, ra, wa, wd);
        do_cmd(4'b0010, 16'hFFFF, 8'h3C, rc, wc, dc, ec, drc, hc, ra, wa, wd);
        checks++; if (wc !== 2) begin errors++; $display("FAIL deposit_we_cycle got %0d want 2", wc); end
        checks++; if ({wa, wd} !== {16'h0100, 8'h3C}) begin errors++; $display("FAIL deposit_write got %h/%h want 0100/3c", wa, wd); end
        checks++; if (rc !== 3) begin errors++; $display("FAIL deposit_readback_cycle got %0d want 3", rc); end
        checks++; if (dc !== 5) begin errors++; $display("FAIL deposit_done_cycle got %0d want 5", dc); end
        checks++; if (panel_data !== 8'h3C) begin errors++; $display("FAIL deposit_panel_data got %h want 3c", panel_data); end
        $display("deposit 0100<=3c: we@%0d done@%0d data=%h", wc, dc, panel_data);
        do_cmd(4'b0001, 16'hFFFF, 8'h7E, rc, wc, dc, ec, drc, hc, ra, wa, wd);
        checks++; if ({wa, wd} !== {16'h0101, 8'h7E}) begin errors++; $display("FAIL deposit_next_write got %h/%h want 0101/7e", wa, wd); end
        checks++; if (panel_addr !== 16'h0101) begin errors++; $display("FAIL deposit_next_panel_addr got %h want 0101", panel_addr); end
        checks++; if (panel_data !== 8'h7E) begin errors++; $display("FAIL deposit_next_panel_data got %h want 7e", panel_data); end
        $display("deposit_next 0101<=7e: done@%0d data=%h", dc, panel_data);
    endtask

    task automatic test_wrap();
        int rc, wc, dc, ec, drc, hc; logic [15:0] ra, wa; logic [7:0] wd;
        do_cmd(4'b1000, 16'hFFFF, 8'h00, rc, wc, dc, ec, drc, hc, ra, wa, wd);
        checks++; if (panel_data !== 8'hC3) begin errors++; $display("FAIL wrap_ffff_data got %h want c3", panel_data); end
        do_cmd(4'b0100, 16'h5555, 8'h00, rc, wc, dc, ec, drc, hc, ra, wa, wd);
        checks++; if (ra !== 16'h0000) begin errors++; $display("FAIL wrap_rd_addr got %h want 0000", ra); end
        checks++; if (panel_addr !== 16'h0000) begin errors++; $display("FAIL wrap_panel_addr got %h want 0000", panel_addr); end
        checks++; if (panel_data !== 8'h42) begin errors++; $display("FAIL wrap_panel_data got %h want 42", panel_data); end
        $display("examine_next after ffff: rd %h data=%h", ra, panel_data);
    endtask

    task automatic test_timeout();
        int rc, wc, dc, ec, drc, hc; logic [15:0] ra, wa; logic [7:0] wd;
        hold_ack = 1'b0;
        do_cmd(4'b1000, 16'h2000, 8'h00, rc, wc, dc, ec, drc, hc, ra, wa, wd);
        hold_ack = 1'b1;
        checks++; if (hc !== 10) begin errors++; $display("FAIL timeout_hold_cycles got %0d want 10", hc); end
        checks++; if (ec !== 11) begin errors++; $display("FAIL timeout_err_cycle got %0d want 11", ec); end
        checks++; if ({rc, wc, dc} !== {-32'sd1, -32'sd1, -32'sd1}) begin errors++; $display("FAIL timeout_no_access got rd=%0d we=%0d done=%0d want -1", rc, wc, dc); end
        checks++; if (panel_addr !== 16'h2000) begin errors++; $display("FAIL timeout_panel_addr got %h want 2000", panel_addr); end
        checks++; if (panel_data !== 8'h42) begin errors++; $display("FAIL timeout_panel_data got %h want 42", panel_data); end
        $display("timeout: hold %0d cycles, err@%0d", hc, ec);
    endtask

    task automatic test_ack_drop();
        sw_addr = 16'h1234; examine_stb = 1'b1;
        @(posedge clk); #1; examine_stb = 1'b0;   // T1 HOLD
        @(posedge clk); #1;                       // T2 READ
        @(posedge clk); #1; hold_ack = 1'b0;      // T3 WAIT
        @(posedge clk); #1;                       // T4 aborted
        checks++; if ({err, hold_req, busy, done} !== 4'b1000) begin errors++; $display("FAIL ackdrop_flags got err/hreq/busy/done=%b want 1000", {err, hold_req, busy, done}); end
        checks++; if (panel_data !== 8'h42) begin errors++; $display("FAIL ackdrop_panel_data got %h want 42", panel_data); end
        hold_ack = 1'b1;
        @(posedge clk); #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ackdrop_err_pulse got %b want 0", err); end
        $display("hold_ack drop in WAIT: aborted, data=%h", panel_data);
    endtask

    task automatic test_collision();
        int rc, wc, dc, ec, drc, hc; logic [15:0] ra, wa; logic [7:0] wd;
        do_cmd(4'b1010, 16'h0300, 8'h55, rc, wc, dc, ec, drc, hc, ra, wa, wd);
        checks++; if (drc !== 1) begin errors++; $display("FAIL collision_drop_cycle got %0d want 1", drc); end
        checks++; if ({rc, wc, dc} !== {32'sd2, -32'sd1, 32'sd4}) begin errors++; $display("FAIL collision_examine_won got rd=%0d we=%0d done=%0d want 2/-1/4", rc, wc, dc); end
        checks++; if (panel_data !== 8'h99) begin errors++; $display("FAIL collision_panel_data got %h want 99", panel_data); end
        $display("examine+deposit collision: drop@%0d data=%h", drc, panel_data);
    endtask

    task automatic test_busy_drop();
        bit saw_we = 0, saw_done = 0;
        sw_addr = 16'h1234; examine_stb = 1'b1;
        @(posedge clk); #1; examine_stb = 1'b0; deposit_stb = 1'b1;
        @(posedge clk); #1; deposit_stb = 1'b0;
        checks++; if (cmd_drop !== 1'b1) begin errors++; $display("FAIL busy_cmd_drop got %b want 1", cmd_drop); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_we) saw_we = 1;
            if (done) saw_done = 1;
        end
        @(posedge clk); #1;
        checks++; if ({saw_we, saw_done} !== 2'b01) begin errors++; $display("FAIL busy_op_result got we/done=%b%b want 01", saw_we, saw_done); end
        checks++; if (panel_data !== 8'hA5) begin errors++; $display("FAIL busy_panel_data got %h want a5", panel_data); end
        $display("strobe while busy: dropped, examine completed data=%h", panel_data);
    endtask

    task automatic test_no_pause();
        pause = 1'b0; sw_addr = 16'h4444; examine_stb = 1'b1;
        @(posedge clk); #1; examine_stb = 1'b0;
        checks++; if ({cmd_drop, hold_req, busy} !== 3'b100) begin errors++; $display("FAIL nopause_flags got drop/hreq/busy=%b want 100", {cmd_drop, hold_req, busy}); end
        @(posedge clk); #1;
        checks++; if ({cmd_drop, hold_req, panel_addr} !== {2'b00, 16'h1234}) begin errors++; $display("FAIL nopause_after got drop=%b hreq=%b pa=%h want 0 0 1234", cmd_drop, hold_req, panel_addr); end
        pause = 1'b1;
        $display("strobe with pause=0: dropped");
    endtask

    task automatic test_async_reset_b();
        int done_seen = 0;
        int dcyc = -1;
        for (int c = 0; c < 20 && b_busy; c++) @(posedge clk);
        #1;
        sw_addr = 16'h0055; examine_stb = 1'b1;
        @(posedge clk); #1; examine_stb = 1'b0;   // T1
        repeat (3) @(posedge clk);                // T4 is second WAIT cycle
        #1;
        checks++; if ({b_busy, b_hold_req} !== 2'b11) begin errors++; $display("FAIL b_midwait got busy/hreq=%b want 11", {b_busy, b_hold_req}); end
        #2; rst_n_b = 1'b0; #1;
        checks++; if ({b_hold_req, b_busy, b_done, b_err, b_mem_addr, b_panel_addr, b_panel_data} !== '0) begin
            errors++; $display("FAIL b_async_reset got hreq=%b busy=%b ma=%h pa=%h want all 0", b_hold_req, b_busy, b_mem_addr, b_panel_addr);
        end
        for (int c = 0; c < 4; c++) begin @(negedge clk); if (b_done) done_seen++; end
        @(posedge clk); #1; rst_n_b = 1'b1;
        for (int c = 0; c < 4; c++) begin @(negedge clk); if (b_done) done_seen++; end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL b_no_done got %0d pulses want 0", done_seen); end
        @(posedge clk); #1;
        sw_addr = 16'h0055; examine_stb = 1'b1;
        @(posedge clk); #1; examine_stb = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (b_done) begin dcyc = c; break; end
        end
        @(posedge clk); #1;
        checks++; if (dcyc !== 6) begin errors++; $display("FAIL b_latency3_done got %0d want 6", dcyc); end
        checks++; if ({b_panel_addr, b_panel_data} !== {16'h0055, 8'h0F}) begin errors++; $display("FAIL b_after_reset got %h/%h want 0055/0f", b_panel_addr, b_panel_data); end
        $display("RD_LATENCY=3 reset mid-WAIT, re-examine done@%0d data=%h", dcyc, b_panel_data);
    endtask

    task automatic test_strobe_rules();
        checks++; if (viol !== 0) begin errors++; $display("FAIL strobe_rules got %0d violations want 0", viol); end
        $display("memory strobe exclusivity/ownership: %0d violations", viol);
    endtask

    initial begin
        test_reset();
        poke(16'h1234, 8'hA5);
        poke(16'hFFFF, 8'hC3);
        poke(16'h0000, 8'h42);
        poke(16'h0300, 8'h99);
        poke(16'h0100, 8'h11);
        test_examine();
        test_deposit();
        test_wrap();
        test_timeout();
        test_ack_drop();
        test_collision();
        test_busy_drop();
        test_no_pause();
        test_async_reset_b();
        test_strobe_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
